// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-cache refill and
// D-cache refill/writeback traffic, with one outstanding transaction at a time.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req_valid,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_rsp_valid,
   output logic [LINE_W-1:0] ic_rsp_rdata,
   input  logic              dc_req_valid,
   input  logic              dc_req_we,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic [LINE_W-1:0] dc_req_wdata,
   output logic              dc_rsp_valid,
   output logic [LINE_W-1:0] dc_rsp_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_rsp_valid,
   input  logic [LINE_W-1:0] mem_rsp_rdata,
   output logic              busy,
   output logic [CNT_W-1:0]  ic_wait_cnt,
   output logic [CNT_W-1:0]  dc_wait_cnt,
   output logic              protocol_err
);

   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   state_e            state_q;
   logic              owner_dc_q;
   logic              last_dc_q;
   logic              mem_req_valid_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [LINE_W-1:0] mem_wdata_q;
   logic              ic_rsp_valid_q;
   logic [LINE_W-1:0] ic_rsp_rdata_q;
   logic              dc_rsp_valid_q;
   logic [LINE_W-1:0] dc_rsp_rdata_q;
   logic              busy_q;
   logic              protocol_err_q;
   logic [CNT_W-1:0]  ic_wait_cnt_q;
   logic [CNT_W-1:0]  ic_wait_cnt_d;
   logic [CNT_W-1:0]  dc_wait_cnt_q;
   logic [CNT_W-1:0]  dc_wait_cnt_d;
   logic              grant_dc;
   logic              grant_ic;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // On a tie the requester that did not win last time gets the port.
   assign grant_dc = dc_req_valid && (!ic_req_valid || !last_dc_q);
   assign grant_ic = ic_req_valid && !grant_dc;

   always_comb begin
      ic_wait_cnt_d = ic_wait_cnt_q;
      dc_wait_cnt_d = dc_wait_cnt_q;
      if (ic_req_valid && !(state_q == S_RESP && !owner_dc_q))
         ic_wait_cnt_d = sat_inc(ic_wait_cnt_q);
      if (dc_req_valid && !(state_q == S_RESP && owner_dc_q))
         dc_wait_cnt_d = sat_inc(dc_wait_cnt_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         owner_dc_q      <= 1'b0;
         last_dc_q       <= 1'b0;
         mem_req_valid_q <= 1'b0;
         mem_we_q        <= 1'b0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         ic_rsp_valid_q  <= 1'b0;
         ic_rsp_rdata_q  <= '0;
         dc_rsp_valid_q  <= 1'b0;
         dc_rsp_rdata_q  <= '0;
         busy_q          <= 1'b0;
         protocol_err_q  <= 1'b0;
         ic_wait_cnt_q   <= '0;
         dc_wait_cnt_q   <= '0;
      end else begin
         ic_wait_cnt_q <= ic_wait_cnt_d;
         dc_wait_cnt_q <= dc_wait_cnt_d;
         if (mem_rsp_valid && state_q != S_WAIT)
            protocol_err_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (grant_dc || grant_ic) begin
                  owner_dc_q      <= grant_dc;
                  last_dc_q       <= grant_dc;
                  mem_req_valid_q <= 1'b1;
                  mem_we_q        <= grant_dc & dc_req_we;
                  mem_addr_q      <= (grant_dc ? dc_req_addr : ic_req_addr) & ADDR_MASK;
                  mem_wdata_q     <= grant_dc ? dc_req_wdata : '0;
                  busy_q          <= 1'b1;
                  state_q         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A writeback acknowledge returns an all-zero line.
               if (mem_rsp_valid) begin
                  if (owner_dc_q) begin
                     dc_rsp_valid_q <= 1'b1;
                     dc_rsp_rdata_q <= mem_we_q ? '0 : mem_rsp_rdata;
                  end else begin
                     ic_rsp_valid_q <= 1'b1;
                     ic_rsp_rdata_q <= mem_rsp_rdata;
                  end
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               ic_rsp_valid_q <= 1'b0;
               ic_rsp_rdata_q <= '0;
               dc_rsp_valid_q <= 1'b0;
               dc_rsp_rdata_q <= '0;
               busy_q         <= 1'b0;
               state_q        <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_req_valid = mem_req_valid_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign ic_rsp_valid  = ic_rsp_valid_q;
   assign ic_rsp_rdata  = ic_rsp_rdata_q;
   assign dc_rsp_valid  = dc_rsp_valid_q;
   assign dc_rsp_rdata  = dc_rsp_rdata_q;
   assign busy          = busy_q;
   assign protocol_err  = protocol_err_q;
   assign ic_wait_cnt   = ic_wait_cnt_q;
   assign dc_wait_cnt   = dc_wait_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single requester, ties and round-robin,
// writeback backpressure, spurious responses and asynchronous reset.
module tb_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 128;
   localparam int CNT_W  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              ic_req_valid;
   logic [ADDR_W-1:0] ic_req_addr;
   logic              ic_rsp_valid;
   logic [LINE_W-1:0] ic_rsp_rdata;
   logic              dc_req_valid;
   logic              dc_req_we;
   logic [ADDR_W-1:0] dc_req_addr;
   logic [LINE_W-1:0] dc_req_wdata;
   logic              dc_rsp_valid;
   logic [LINE_W-1:0] dc_rsp_rdata;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic              mem_rsp_valid;
   logic [LINE_W-1:0] mem_rsp_rdata;
   logic              busy;
   logic [CNT_W-1:0]  ic_wait_cnt;
   logic [CNT_W-1:0]  dc_wait_cnt;
   logic              protocol_err;

   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
      .ic_rsp_valid(ic_rsp_valid), .ic_rsp_rdata(ic_rsp_rdata),
      .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we),
      .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata),
      .dc_rsp_valid(dc_rsp_valid), .dc_rsp_rdata(dc_rsp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .busy(busy), .ic_wait_cnt(ic_wait_cnt), .dc_wait_cnt(dc_wait_cnt),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      ic_req_valid  = 1'b0;
      ic_req_addr   = '0;
      dc_req_valid  = 1'b0;
      dc_req_we     = 1'b0;
      dc_req_addr   = '0;
      dc_req_wdata  = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Called in an IDLE cycle with requests applied; returns in the RESP cycle.
   task automatic xact(input string tag, input bit exp_dc, input logic [31:0] exp_addr,
                       input bit exp_we, input logic [127:0] rd);
      tick();
      chk({tag, "_req_valid"}, mem_req_valid, 1'b1);
      chk({tag, "_addr"}, mem_addr, exp_addr);
      chk({tag, "_we"}, mem_we, exp_we);
      mem_req_ready = 1'b1;
      tick();
      chk({tag, "_req_drop"}, mem_req_valid, 1'b0);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rd;
      tick();
      mem_rsp_valid = 1'b0;
      chk({tag, "_dc_rsp_valid"}, dc_rsp_valid, exp_dc);
      chk({tag, "_ic_rsp_valid"}, ic_rsp_valid, !exp_dc);
      chk({tag, "_dc_rdata"}, dc_rsp_rdata, (exp_dc && !exp_we) ? rd : 128'h0);
      chk({tag, "_ic_rdata"}, ic_rsp_rdata, exp_dc ? 128'h0 : rd);
   endtask

   initial begin
      do_reset();
      // reset state
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_req_valid", mem_req_valid, 1'b0);
      chk("rst_ic_rsp", ic_rsp_valid, 1'b0);
      chk("rst_dc_rsp", dc_rsp_valid, 1'b0);
      chk("rst_ic_cnt", ic_wait_cnt, 0);
      chk("rst_dc_cnt", dc_wait_cnt, 0);
      chk("rst_perr", protocol_err, 1'b0);

      // IC only, minimum latency
      ic_req_valid = 1'b1;
      ic_req_addr  = 32'h0000_1234;
      xact("ic_only", 1'b0, 32'h0000_1230, 1'b0, {4{32'hA5A5_A5A5}});
      ic_req_valid = 1'b0;
      chk("ic_only_cnt", ic_wait_cnt, 3);
      chk("ic_only_busy_resp", busy, 1'b1);
      tick();
      chk("ic_only_busy_idle", busy, 1'b0);
      chk("ic_only_pulse_end", ic_rsp_valid, 1'b0);
      chk("ic_only_cnt_hold", ic_wait_cnt, 3);

      // tie after reset, then round-robin with both held valid
      do_reset();
      ic_req_valid = 1'b1;
      ic_req_addr  = 32'h0000_1234;
      dc_req_valid = 1'b1;
      dc_req_we    = 1'b0;
      dc_req_addr  = 32'h0000_2008;
      xact("rr0_dc", 1'b1, 32'h0000_2000, 1'b0, {4{32'hC0DE_0000}});
      chk("rr0_ic_cnt", ic_wait_cnt, 3);
      chk("rr0_dc_cnt", dc_wait_cnt, 3);
      tick();
      xact("rr1_ic", 1'b0, 32'h0000_1230, 1'b0, {4{32'hC0DE_0001}});
      chk("rr1_ic_cnt", ic_wait_cnt, 7);
      chk("rr1_dc_cnt", dc_wait_cnt, 6);
      tick();
      xact("rr2_dc", 1'b1, 32'h0000_2000, 1'b0, {4{32'hC0DE_0002}});
      tick();
      xact("rr3_ic", 1'b0, 32'h0000_1230, 1'b0, {4{32'hC0DE_0003}});
      ic_req_valid = 1'b0;
      dc_req_valid = 1'b0;

      // DC writeback with 4 cycles of backpressure
      do_reset();
      dc_req_valid = 1'b1;
      dc_req_we    = 1'b1;
      dc_req_addr  = 32'h0000_ABCF;
      dc_req_wdata = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("wb_valid_%0d", i), mem_req_valid, 1'b1);
         chk($sformatf("wb_addr_%0d", i), mem_addr, 32'h0000_ABC0);
         chk($sformatf("wb_we_%0d", i), mem_we, 1'b1);
         chk($sformatf("wb_wdata_%0d", i), mem_wdata, 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00);
         mem_req_ready = (i == 4);
      end
      tick();
      mem_req_ready = 1'b0;
      chk("wb_valid_drop", mem_req_valid, 1'b0);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = {4{32'hDEAD_BEEF}};
      tick();
      mem_rsp_valid = 1'b0;
      dc_req_valid  = 1'b0;
      chk("wb_dc_rsp", dc_rsp_valid, 1'b1);
      chk("wb_dc_rdata", dc_rsp_rdata, 128'h0);
      chk("wb_ic_rsp", ic_rsp_valid, 1'b0);
      chk("wb_dc_cnt", dc_wait_cnt, 7);
      chk("wb_perr", protocol_err, 1'b0);
      tick();

      // spurious response while IDLE
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = {4{32'h5555_AAAA}};
      tick();
      mem_rsp_valid = 1'b0;
      chk("spur_perr", protocol_err, 1'b1);
      chk("spur_ic_rsp", ic_rsp_valid, 1'b0);
      chk("spur_dc_rsp", dc_rsp_valid, 1'b0);
      chk("spur_busy", busy, 1'b0);
      tick();
      chk("spur_perr_sticky", protocol_err, 1'b1);
      ic_req_valid = 1'b1;
      ic_req_addr  = 32'h0000_4444;
      xact("spur_next", 1'b0, 32'h0000_4440, 1'b0, {4{32'h0F0F_1234}});
      ic_req_valid = 1'b0;
      tick();
      chk("spur_perr_end", protocol_err, 1'b1);

      // asynchronous reset while in WAIT
      do_reset();
      ic_req_valid = 1'b1;
      ic_req_addr  = 32'h0000_8888;
      tick();
      chk("ar_issue", mem_req_valid, 1'b1);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("ar_wait_busy", busy, 1'b1);
      chk("ar_wait_cnt", ic_wait_cnt, 2);
      #2;
      rst          = 1'b1;
      ic_req_valid = 1'b0;
      #1;
      chk("ar_busy", busy, 1'b0);
      chk("ar_addr", mem_addr, 32'h0);
      chk("ar_ic_cnt", ic_wait_cnt, 0);
      #1;
      rst = 1'b0;
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = {4{32'h7777_7777}};
      tick();
      mem_rsp_valid = 1'b0;
      chk("ar_late_ic_rsp", ic_rsp_valid, 1'b0);
      chk("ar_late_dc_rsp", dc_rsp_valid, 1'b0);
      chk("ar_late_perr", protocol_err, 1'b1);
      chk("ar_late_busy", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
